// File: rtl/pulse_burst_controller.sv
// pulse_burst_controller
// Issues a bounded train of single-cycle strobes. A start request in IDLE latches
// the period and pulse count. Pulses are then spaced by that period, and done
// fires once after the last pulse. abort ends a burst early without done.
module pulse_burst_controller #(
    parameter int PeriodWidth = 16,
    parameter int CountWidth  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PeriodWidth-1:0] period,
    input  logic [CountWidth-1:0]  count,
    output logic                   pulse,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [CountWidth-1:0]  remaining
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [PeriodWidth-1:0] PHASE_ONE = PeriodWidth'(1);
    localparam logic [CountWidth-1:0]  REM_ONE   = CountWidth'(1);

    logic [1:0]             state_q,  state_d;
    logic [PeriodWidth-1:0] phase_q,  phase_d;
    logic [PeriodWidth-1:0] period_q, period_d;
    logic [CountWidth-1:0]  rem_q,    rem_d;
    logic                   pulse_q,  pulse_d;
    logic                   done_q,   done_d;
    logic                   err_q,    err_d;

    // Next-state logic. Strobe outputs default low so that each one lasts a single cycle.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        period_d = period_q;
        rem_d    = rem_q;
        pulse_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((period == '0) || (count == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        period_d = period;
                        rem_d    = count;
                        phase_d  = PHASE_ONE;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // abort takes priority over a pulse that falls due on the same edge
                if (abort) begin
                    rem_d   = '0;
                    state_d = S_IDLE;
                end else if (phase_q == period_q) begin
                    pulse_d = 1'b1;
                    phase_d = PHASE_ONE;
                    rem_d   = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = S_DONE;
                    end
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end
            S_DONE: begin
                // abort is ignored here, so done always fires
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears everything at once, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            period_q <= '0;
            rem_q    <= '0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            rem_q    <= rem_d;
            pulse_q  <= pulse_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign pulse     = pulse_q;
    assign done      = done_q;
    assign err       = err_q;
    assign remaining = rem_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pulse_burst_controller.sv
// Bench for pulse_burst_controller. It runs directed scenarios and then random
// traffic. An arithmetic reference model describes each burst by its acceptance
// edge, its period and its count.
module tb_pulse_burst_controller;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] period;
    logic [7:0]  count;
    logic        pulse;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  remaining;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: one burst described by acceptance edge t0, period P and count N.
    int  t        = 0;
    bit  active   = 0;
    int  t0       = 0;
    int  mp       = 0;
    int  mn       = 0;
    bit  err_e    = 0;
    int  pulse_ct = 0;

    pulse_burst_controller #(.PeriodWidth(16), .CountWidth(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .period(period), .count(count),
        .pulse(pulse), .busy(busy), .done(done), .err(err), .remaining(remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", tag, t, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int d;
        int np;
        int e_pulse;
        int e_busy;
        int e_done;
        int e_rem;
        e_pulse = 0;
        e_busy  = 0;
        e_done  = 0;
        e_rem   = 0;
        if (active) begin
            d  = t - t0;
            np = mn * mp;
            e_pulse = (d > 0 && d <= np && (d % mp) == 0) ? 1 : 0;
            e_busy  = (d <= np) ? 1 : 0;
            e_done  = (d == np + 1) ? 1 : 0;
            e_rem   = (d <= np) ? (mn - d / mp) : 0;
        end
        check_val("pulse", int'(pulse), e_pulse);
        check_val("busy", int'(busy), e_busy);
        check_val("done", int'(done), e_done);
        check_val("err", int'(err), int'(err_e));
        check_val("remaining", int'(remaining), e_rem);
    endtask

    // One clock: drive the inputs, take the edge, advance the model, then check just after the edge.
    task automatic cyc(input bit s, input bit a, input int p, input int c);
        bit in_run;
        bit in_idle;
        start  = s;
        abort  = a;
        period = 16'(p);
        count  = 8'(c);
        @(posedge clk);
        t++;
        err_e = 0;
        if (rst) begin
            active = 0;
        end else begin
            in_run  = active && (t <= t0 + mn * mp);
            in_idle = !active || (t > t0 + mn * mp + 1);
            if (in_run) begin
                if (a) active = 0;
            end else if (in_idle && s) begin
                if (p == 0 || c == 0) begin
                    err_e  = 1;
                    active = 0;
                end else begin
                    active = 1;
                    t0 = t;
                    mp = p;
                    mn = c;
                end
            end
        end
        #1;
        check_outputs();
        if (pulse === 1'b1) pulse_ct++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; period = '0; count = '0;
        #1;
        check_outputs();

        // Reset hold: start requests while in reset must have no effect
        for (int i = 0; i < 100; i++) cyc(1, 0, 3, 4);
        rst = 1'b0;

        // Basic burst with period 3 and count 4
        cyc(1, 0, 3, 4);
        for (int i = 0; i < 16; i++) cyc(0, 0, 3, 4);

        // period 1: consecutive pulses
        cyc(1, 0, 1, 5);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 5);

        // Zero period or zero count is rejected
        cyc(1, 0, 0, 4);
        cyc(0, 0, 0, 4);
        cyc(1, 0, 5, 0);
        cyc(0, 0, 5, 0);
        cyc(0, 0, 5, 0);

        // Abort on the edge where pulse 2 is due
        cyc(1, 0, 16, 10);
        for (int i = 1; i < 32; i++) cyc(0, 0, 16, 10);
        cyc(0, 1, 16, 10);
        for (int i = 0; i < 20; i++) cyc(0, 0, 16, 10);

        // start held high: no restart mid-burst, second burst taken in the done cycle
        pulse_ct = 0;
        for (int i = 0; i < 9; i++) cyc(1, 0, 2, 3);
        for (int i = 0; i < 10; i++) cyc(0, 0, 2, 3);
        check_val("b2b_pulses", pulse_ct, 6);

        // period input changed after acceptance
        cyc(1, 0, 2, 3);
        for (int i = 0; i < 10; i++) cyc(0, 0, 7, 1);

        // Asynchronous reset between edges during RUN
        cyc(1, 0, 5, 3);
        for (int i = 0; i < 6; i++) cyc(0, 0, 5, 3);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_pulse", int'(pulse), 0);
        check_val("async_busy", int'(busy), 0);
        check_val("async_done", int'(done), 0);
        check_val("async_err", int'(err), 0);
        check_val("async_rem", int'(remaining), 0);
        cyc(0, 0, 5, 3);
        rst = 1'b0;
        cyc(1, 0, 4, 2);
        for (int i = 0; i < 11; i++) cyc(0, 0, 4, 2);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
        end
        for (int i = 0; i < 40; i++) cyc(0, 0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pulse_burst_controller.md
# pulse_burst_controller

Sequences a programmable burst of single-cycle strobes: on a start request it latches a runtime period and pulse count, emits exactly that many one-cycle pulses spaced by the period, then signals completion. It replaces fixed-period strobe generation wherever software or an upstream FSM needs a bounded, restartable, abortable pulse train, such as symbol-rate strobes for a fixed-length frame or timed sample bursts. It sits between a control requester (start/abort/busy/done handshake) and any datapath stage that consumes an enable strobe.

## Interface
- PeriodWidth, default 16: width of the `period` input and the internal phase counter.
- CountWidth, default 8: width of `count` and `remaining`.

- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset; all state and outputs clear immediately on assertion.
- start  input  1  request a burst; sampled on rising edges, accepted only in IDLE.
- abort  input  1  terminate an active burst; sampled on rising edges.
- period  input  PeriodWidth  clocks between pulses; latched on acceptance.
- count  input  CountWidth  pulses in the burst; latched on acceptance.
- pulse  output  1  one-cycle strobe, registered.
- busy  output  1  high while a burst is in progress (RUN or DONE).
- done  output  1  one-cycle completion flag, registered.
- err  output  1  one-cycle flag: start rejected because period or count was zero.
- remaining  output  CountWidth  pulses not yet issued in the current burst; 0 in IDLE.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE. All outputs are 0 in reset.
- IDLE with start=1, period!=0, count!=0: latch period_q and count, set remaining<=count, set phase<=1, go to RUN.
- IDLE with start=1 and period==0 or count==0: err<=1 for one cycle, stay IDLE, latch nothing.
- In RUN or DONE, start is ignored and no err is raised. Requesters must watch busy.
- Each RUN edge with phase==period_q: pulse<=1, phase<=1, remaining<=remaining-1. If remaining was 1, go to DONE.
- Each RUN edge with phase!=period_q: phase<=phase+1, pulse<=0.
- DONE lasts one edge: done<=1, pulse<=0, go to IDLE.
- abort=1 on an edge in RUN: go to IDLE, pulse<=0, remaining<=0, no done. abort has priority over a pulse due on the same edge.
- abort in DONE: no effect, and done still fires. abort in IDLE: no effect.
- Arithmetic: phase is unsigned PeriodWidth, compared for equality only, so there is no wrap. The maximum period is 2^PeriodWidth-1.
- Changes to period and count after acceptance have no effect on the running burst.

## Timing
- Acceptance edge E0. Pulse k (k=1..count) is high in the cycle following edge E0+k*period.
- period=1 gives a pulse every cycle, count consecutive cycles.
- busy rises in the cycle after E0. It falls at the same edge done rises, which is the edge after the last pulse edge.
- done is high in the single cycle after the last pulse cycle. The state is IDLE in that cycle, so a start asserted during done is accepted.
  - This gives back-to-back bursts with a 1-cycle gap in busy.
- err is high in the cycle after the rejecting edge.
- remaining decrements at the same edge pulse rises. It reads 0 during the last pulse cycle.
- Asynchronous rst mid-burst: pulse, busy, done, err and remaining drop to 0 immediately, without waiting for a clock edge. The first start after rst release is accepted normally.

## Test plan
- Reset hold: rst=1 for 100 cycles with start=1, period=3, count=4. Required: pulse, busy, done and err stay 0 throughout.
- Basic burst: period=3, count=4, start pulsed at E0. Required:
  - pulse high after E3, E6, E9 and E12 only;
  - remaining reads 4,3,2,1,0;
  - done high after E13;
  - busy high from after E0 through the cycle after E12.
- Boundary values:
  - period=1, count=5: five consecutive pulses after E1–E5, done after E6.
  - period=0 or count=0: err for one cycle, busy stays 0, no pulse.
- Abort: period=16, count=10, abort asserted at E32, the edge where pulse 2 is due. Required: no pulse after E32, busy and remaining become 0, done never asserts.
- Back-to-back and busy-ignore:
  - start held high through a period=2, count=3 burst. Required: no restart mid-burst; a second burst is accepted in the done cycle; exactly 6 pulses total.
  - period changed mid-burst. Required: spacing stays 2.
- Async reset mid-burst: rst asserted between clock edges during RUN. Required: all outputs 0 before the next clk edge. A new burst with period=4, count=2 after release pulses after E4 and E8.
